// File: rtl/aes_pkg.sv
// Shared AES constants: the FIPS-197 forward S-box table, state geometry and
// a lookup helper used by the SubBytes lanes.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    // Forward S-box, indexed by the input byte value.
    localparam logic [7:0] AES_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// One SubBytes lane: purely combinational 8-bit forward S-box lookup.
module aes_sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);

    // Table lookup through the shared package helper.
    always_comb begin
        out = aes_pkg::aes_sbox(in);
    end

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes stage: sixteen independent S-box lanes feeding a single
// output register stage with a valid flag.
module sub_bytes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in,
    output logic         out_valid,
    output logic [127:0] out
);

    logic [AES_STATE_W-1:0] sub_s;
    logic [AES_STATE_W-1:0] out_r;
    logic                   out_valid_r;

    // Byte 0 lives in the most significant byte; lanes keep their positions.
    for (genvar k = 0; k < AES_BYTES; k++) begin : g_lane
        aes_sbox u_sbox (
            .in  (in[AES_STATE_W-1-8*k -: 8]),
            .out (sub_s[AES_STATE_W-1-8*k -: 8])
        );
    end

    // Output register: load on valid, otherwise hold data and drop the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= {AES_STATE_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                out_r <= sub_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes; the reference S-box is derived from
// GF(2^8) inversion plus the affine map rather than from a table.
module tb_sub_bytes;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_valid;
    logic [127:0] out_state;

    int tests_run;
    int tests_failed;

    logic [7:0]   ref_sbox [0:255];
    logic [127:0] exp_out;
    logic         exp_valid;

    sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_state),
        .out_valid (out_valid),
        .out       (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_sbox[s[127-8*k -: 8]];
        return r;
    endfunction

    // Drive one cycle on the falling edge, then sample just after the rising edge.
    task automatic cycle(input logic v, input logic [127:0] d);
        @(negedge clk);
        in_valid = v;
        in_state = d;
        if (v) exp_out = ref_state(d);
        exp_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] prev;
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'h0;
        exp_out   = 128'h0;
        exp_valid = 1'b0;
        for (int v = 0; v < 256; v++) ref_sbox[v] = sbox_math(8'(v));

        #12;
        check("reset_out", out_state, 128'h0);
        check("reset_valid", {127'h0, out_valid}, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 128'h19A09AE93DF4C6F8E3E28D48BE2B2A08);
        check("fips_round1", out_state, 128'hD4E0B81E27BFB44111985D52AEF1E530);
        check("fips_valid", {127'h0, out_valid}, 128'h1);
        cycle(1'b1, 128'h0);
        check("all_zero", out_state, 128'h63636363636363636363636363636363);
        cycle(1'b1, {128{1'b1}});
        check("all_ff", out_state, 128'h16161616161616161616161616161616);
        cycle(1'b1, 128'h000102030405060708090A0B0C0D0E0F);
        check("lanes", out_state, 128'h637C777BF26B6FC53001672BFED7AB76);

        for (int v = 0; v < 256; v++) begin
            cycle(1'b1, {16{8'(v)}});
            check("exhaustive", out_state, {16{ref_sbox[v]}});
            if (v == 8'h53) check("sbox_53", out_state, {16{8'hED}});
            if (v == 8'h01) check("sbox_01", out_state, {16{8'h7C}});
            if (v == 8'h10) check("sbox_10", out_state, {16{8'hCA}});
        end

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand128());
            check("stream_out", out_state, exp_out);
            check("stream_valid", {127'h0, out_valid}, 128'h1);
        end
        prev = exp_out;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, rand128());
            check("hold_out", out_state, prev);
            check("hold_valid", {127'h0, out_valid}, 128'h0);
        end
        cycle(1'b0, 128'hx);
        check("hold_x_out", out_state, prev);

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), rand128());
            check("rand_out", out_state, exp_out);
            check("rand_valid", {127'h0, out_valid}, {127'h0, exp_valid});
        end

        cycle(1'b1, 128'h19A09AE93DF4C6F8E3E28D48BE2B2A08);
        @(negedge clk);
        in_valid = 1'b1;
        in_state = rand128();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", out_state, 128'h0);
        check("async_rst_valid", {127'h0, out_valid}, 128'h0);
        @(posedge clk);
        #1;
        check("rst_held_out", out_state, 128'h0);
        check("rst_held_valid", {127'h0, out_valid}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_out = 128'h0;
        cycle(1'b1, 128'h000102030405060708090A0B0C0D0E0F);
        check("post_rst_out", out_state, 128'h637C777BF26B6FC53001672BFED7AB76);
        check("post_rst_valid", {127'h0, out_valid}, 128'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
